// File: rtl/tqvp_spike_odometry_tx_if.sv
// TinyQV peripheral bus bundle for the spike odometry transmitter.
// The host drives address/write data; the peripheral returns read data and ready.
interface tqvp_spike_odometry_tx_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/tqvp_spike_odometry_tx.sv
// Spike-train transmitter: queued motion commands become one-hot direction pulses
// on uo_out[3:0], with net displacement tracking and a queue-drained interrupt.
module tqvp_spike_odometry_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_W    = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     ui_in,
  output logic [7:0]                     uo_out,
  tqvp_spike_odometry_tx_if.slave        bus,
  output logic                           user_interrupt
);
  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [16:0]     PMIN    = 17'(PULSE_W + 1);
  localparam logic [15:0]     HI_LOAD = 16'(PULSE_W - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  typedef struct packed {
    logic [1:0]  dir;
    logic [15:0] count;
  } cmd_t;

  // Register decode
  logic wr, push_req, ctrl_wr, period_wr, status_wr, net_clr, flush;
  assign wr        = (bus.data_write_n == 2'b10);
  assign push_req  = wr && (bus.address == 6'h00);
  assign ctrl_wr   = wr && (bus.address == 6'h04);
  assign period_wr = wr && (bus.address == 6'h08);
  assign status_wr = wr && (bus.address == 6'h0C);
  assign net_clr   = wr && (bus.address == 6'h14);
  assign flush     = ctrl_wr && bus.data_in[1];

  logic        en_q, irq_en_q, ovf_q, done_q, irq_q;
  logic [15:0] period_q;
  logic [15:0] net_x_q, net_y_q;

  // Command queue
  cmd_t        fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic        empty, full, pop, push_ok;
  cmd_t        head, cmd_in;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == DEPTH_L);
  assign head    = fifo_mem[rd_ptr[AW-1:0]];
  assign cmd_in  = cmd_t'{dir: bus.data_in[17:16], count: bus.data_in[15:0]};
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_req && (!full || pop);

  // NOTE: storage arrays carry no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= cmd_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Pulse sequencer
  state_t      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [15:0] cnt_q, cnt_d, timer_q, timer_d, low_load;
  logic [16:0] peff;
  logic        hi_entry, done_set, hold;

  assign hold     = ui_in[0];
  assign peff     = ({1'b0, period_q} < PMIN) ? PMIN : {1'b0, period_q};
  assign low_load = 16'(peff - PMIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    pop      = 1'b0;
    hi_entry = 1'b0;
    done_set = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: if (en_q && !empty) begin
          pop = 1'b1;
          if (head.count != '0) begin
            dir_d    = head.dir;
            cnt_d    = head.count;
            timer_d  = HI_LOAD;
            state_d  = HIGH;
            hi_entry = 1'b1;
          end
        end
        HIGH: if (timer_q == '0) begin
          cnt_d   = cnt_q - 16'd1;
          timer_d = low_load;
          state_d = LOW;
        end else begin
          timer_d = timer_q - 16'd1;
        end
        LOW: if (timer_q != '0) begin
          timer_d = timer_q - 16'd1;
        end else if (cnt_q == '0) begin
          state_d  = IDLE;
          done_set = empty;
        end else if (!hold && en_q) begin
          timer_d  = HI_LOAD;
          state_d  = HIGH;
          hi_entry = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control/status registers and net displacement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= 16'd4;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      net_x_q  <= '0;
      net_y_q  <= '0;
    end else begin
      if (ctrl_wr) begin
        en_q     <= bus.data_in[0];
        irq_en_q <= bus.data_in[2];
      end
      if (period_wr) period_q <= bus.data_in[15:0];
      if (push_req && full && !pop)           ovf_q <= 1'b1;
      else if (status_wr && bus.data_in[6])   ovf_q <= 1'b0;
      if (done_set)                           done_q <= 1'b1;
      else if (status_wr && bus.data_in[8])   done_q <= 1'b0;
      irq_q <= done_q & irq_en_q;
      // A clear coincident with a spike entry discards that spike.
      if (net_clr) begin
        net_x_q <= '0;
        net_y_q <= '0;
      end else if (hi_entry) begin
        case (dir_d)
          2'd0:    net_x_q <= net_x_q + 16'd1;
          2'd1:    net_y_q <= net_y_q + 16'd1;
          2'd2:    net_x_q <= net_x_q - 16'd1;
          default: net_y_q <= net_y_q - 16'd1;
        endcase
      end
    end
  end

  logic        busy;
  logic [3:0]  lines;
  logic [31:0] level_ext;
  assign busy      = (state_q != IDLE);
  assign lines     = (state_q == HIGH) ? (4'b0001 << dir_q) : 4'b0000;
  assign level_ext = 32'(level);

  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      6'h04:   bus.data_out = {29'b0, irq_en_q, 1'b0, en_q};
      6'h08:   bus.data_out = {16'b0, period_q};
      6'h0C:   bus.data_out = {23'b0, done_q, 1'b0, ovf_q, empty, full, busy, level_ext[2:0]};
      6'h10:   bus.data_out = busy ? {14'b0, dir_q, cnt_q} : 32'b0;
      6'h14:   bus.data_out = {net_y_q, net_x_q};
      default: bus.data_out = '0;
    endcase
  end

  assign uo_out         = {3'b000, busy, lines};
  assign bus.data_ready = 1'b1;
  assign user_interrupt = irq_q;

  logic unused;
  assign unused = ^{ui_in[7:1], bus.data_read_n, bus.data_in[31:18]};
endmodule

// File: tb/tb_tqvp_spike_odometry_tx.sv
// Directed bench for the spike odometry transmitter (FIFO_DEPTH=4, PULSE_W=1).
`timescale 1ns/1ps
module tb_tqvp_spike_odometry_tx;
  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic       user_interrupt;
  int         n_cmp;
  int         n_err;
  logic [31:0] d;

  tqvp_spike_odometry_tx_if bus ();

  tqvp_spike_odometry_tx #(.FIFO_DEPTH(4), .PULSE_W(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .bus            (bus),
    .user_interrupt (user_interrupt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] v);
    bus.address      = a;
    bus.data_in      = v;
    bus.data_write_n = 2'b10;
    tick();
    bus.data_write_n = 2'b11;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    bus.address = a;
    #0.01;
    d = bus.data_out;
    check(tag, d, exp);
  endtask

  task automatic expect_uo(input string tag, input int n, input logic [7:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, 32'(uo_out), 32'(exp));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ui_in = 8'h00;
    bus.address      = 6'h00;
    bus.data_in      = 32'h0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;

    // Reset state
    repeat (2) tick();
    check("rst_uo", 32'(uo_out), 32'h0);
    check("rst_dout", bus.data_out, 32'h0);
    check("rst_irq", 32'(user_interrupt), 32'h0);
    rd_chk("rst_status", 6'h0C, 32'h20);
    rd_chk("rst_period", 6'h08, 32'h4);
    rd_chk("rst_ctrl",   6'h04, 32'h0);
    rd_chk("rst_net",    6'h14, 32'h0);
    rd_chk("rst_cur",    6'h10, 32'h0);
    rst_n = 1'b1;
    tick();

    // Three +x spikes at PERIOD=4, then DONE and interrupt
    wr(6'h04, 32'h5);
    wr(6'h00, 32'h0000_0003);
    check("t1_c1", 32'(uo_out), 32'h0);
    for (int c = 2; c <= 13; c++) begin
      tick();
      check("t1_spike", 32'(uo_out), (c == 2 || c == 6 || c == 10) ? 32'h11 : 32'h10);
    end
    rd_chk("t1_st_busy", 6'h0C, 32'h28);
    tick();
    rd_chk("t1_st_done", 6'h0C, 32'h120);
    check("t1_irq_lag", 32'(user_interrupt), 32'h0);
    check("t1_uo_idle", 32'(uo_out), 32'h0);
    tick();
    check("t1_irq", 32'(user_interrupt), 32'h1);
    rd_chk("t1_net", 6'h14, 32'h0000_0003);
    wr(6'h0C, 32'h100);
    rd_chk("t1_w1c", 6'h0C, 32'h20);
    tick();
    check("t1_irq_clr", 32'(user_interrupt), 32'h0);
    wr(6'h14, 32'h0);
    rd_chk("t1_net_clr", 6'h14, 32'h0);

    // Fill queue with EN=0, overflow and W1C
    wr(6'h04, 32'h0);
    wr(6'h00, 32'h0002_0002);
    wr(6'h00, 32'h0001_0000);
    wr(6'h00, 32'h0001_0001);
    wr(6'h00, 32'h0000_000A);
    wr(6'h00, 32'h0003_0007);
    rd_chk("t2_full_ovf", 6'h0C, 32'h54);
    wr(6'h0C, 32'h40);
    rd_chk("t2_ovf_clr", 6'h0C, 32'h14);

    // Drain: -x pair, zero-count skip, +y single, +x x10 with hold
    wr(6'h04, 32'h1);
    check("t2_e1", 32'(uo_out), 32'h0);
    expect_uo("t2_mx_a", 1, 8'h14);
    expect_uo("t2_lo_a", 3, 8'h10);
    expect_uo("t2_mx_b", 1, 8'h14);
    expect_uo("t2_lo_b", 3, 8'h10);
    expect_uo("t2_idle_a", 1, 8'h00);
    rd_chk("t2_net_mx", 6'h14, 32'h0000_FFFE);
    rd_chk("t2_level3", 6'h0C, 32'h03);
    expect_uo("t2_skip", 1, 8'h00);
    expect_uo("t2_py", 1, 8'h12);
    expect_uo("t2_lo_c", 3, 8'h10);
    expect_uo("t2_idle_b", 1, 8'h00);
    expect_uo("t2_px_1", 1, 8'h11);
    expect_uo("t2_lo_d", 3, 8'h10);
    expect_uo("t2_px_2", 1, 8'h11);
    rd_chk("t2_net_py", 6'h14, 32'h0001_0000);
    ui_in = 8'h01;
    expect_uo("t2_hold", 9, 8'h10);
    rd_chk("t2_cur", 6'h10, 32'h0000_0008);
    ui_in = 8'h00;
    for (int k = 0; k < 8; k++) begin
      expect_uo("t2_resume_hi", 1, 8'h11);
      expect_uo("t2_resume_lo", 3, 8'h10);
    end
    expect_uo("t2_end", 1, 8'h00);
    rd_chk("t2_done", 6'h0C, 32'h120);
    rd_chk("t2_net_end", 6'h14, 32'h0001_0008);

    // PERIOD=1 gives Peff=2; FLUSH mid-command
    wr(6'h0C, 32'h100);
    wr(6'h08, 32'h1);
    rd_chk("t3_period", 6'h08, 32'h1);
    wr(6'h00, 32'h0003_0005);
    wr(6'h00, 32'h0000_0003);
    check("t3_my_a", 32'(uo_out), 32'h18);
    expect_uo("t3_lo", 1, 8'h10);
    expect_uo("t3_my_b", 1, 8'h18);
    rd_chk("t3_st_run", 6'h0C, 32'h09);
    wr(6'h04, 32'h3);
    check("t3_flush_uo", 32'(uo_out), 32'h0);
    rd_chk("t3_flush_st", 6'h0C, 32'h20);
    rd_chk("t3_ctrl_rd", 6'h04, 32'h1);
    tick();
    check("t3_flush_uo2", 32'(uo_out), 32'h0);
    rd_chk("t3_flush_st2", 6'h0C, 32'h20);
    rd_chk("t3_net", 6'h14, 32'hFFFF_0008);

    // Asynchronous reset during a pulse
    wr(6'h00, 32'h0001_0004);
    tick();
    check("t4_pre", 32'(uo_out), 32'h12);
    #1;
    rst_n = 1'b0;
    #1;
    check("t4_rst_uo", 32'(uo_out), 32'h0);
    check("t4_rst_irq", 32'(user_interrupt), 32'h0);
    rd_chk("t4_rst_net", 6'h14, 32'h0);
    rd_chk("t4_rst_st", 6'h0C, 32'h20);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tqvp_spike_odometry_tx.md
Name: tqvp_spike_odometry_tx

Overview:
- Spike-train transmitter for the neuromorphic navigation interface. The host CPU queues motion commands over the TinyQV peripheral bus.
- The block emits direction-coded spike pulses on uo_out[3:0]: bit0 +x, bit1 +y, bit2 -x, bit3 -y. This is the same one-hot rising-edge format the SLAM odometry peripheral consumes on ui_in[3:0].
- Tracks the net emitted displacement and raises an interrupt when the command queue drains.

Parameters:
- FIFO_DEPTH, 4, command queue depth (power of 2, ≥2).
- PULSE_W, 1, spike high time in clocks (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ui_in  in  8  ui_in[0]=hold (pause between spikes); [7:1] unused
- uo_out  out  8  [3:0] spike lines, [4] busy, [7:5]=0
- address  in  6  register address
- data_in  in  32  write data
- data_write_n  in  2  11=no write, 10=32-bit write; 01/00 (sub-word) ignored by all registers
- data_read_n  in  2  unused
- data_out  out  32  read data, combinational from address
- data_ready  out  1  tied 1
- user_interrupt  out  1  done interrupt

Behaviour:
- Reset: uo_out=0, data_out=0 (addr 0), user_interrupt=0. FIFO empty, state IDLE, CTRL=0, PERIOD=4, net counters=0, sticky flags=0.
- 0x00 CMD (W)
  - Write pushes {dir=data_in[17:16], count=data_in[15:0]}; reads 0.
  - Push when full is dropped and sets sticky OVF, unless a pop occurs the same cycle, in which case the push is accepted.
- 0x04 CTRL (RW)
  - bit0 EN, bit2 IRQ_EN.
  - bit1 FLUSH is self-clearing: next cycle FIFO emptied, current command aborted, state→IDLE, spike lines low. DONE is not set. Reads 0.
- 0x08 PERIOD (RW) [15:0]
  - Effective period Peff = max(PERIOD, PULSE_W+1).
- 0x0C STATUS (R, W1C)
  - [2:0] level, [3] busy (state≠IDLE), [4] full, [5] empty, [6] OVF, [8] DONE.
  - Writing 1 to bit6/bit8 clears that flag.
- 0x10 CUR (R): {14'b0, cur_dir, remaining count}; 0 in IDLE.
- 0x14 NET (R, any 32-bit write clears): {net_y[15:0], net_x[15:0]}, two's-complement, wraps mod 2^16.
- Unmapped addresses read 0.
- FSM IDLE/HIGH/LOW:
  - IDLE: if EN && !empty, pop head.
    - count==0: discard, stay IDLE.
    - Else: load cur_dir, cur_cnt=count, timer=PULSE_W-1, →HIGH.
  - HIGH: uo_out[cur_dir] driven 1 (combinational from state register).
    - On entry, net counter for cur_dir ±1.
    - At timer==0: cur_cnt--, timer=Peff-PULSE_W-1, →LOW.
  - LOW: lines 0.
    - At timer==0:
      - cur_cnt==0: →IDLE. If FIFO empty that cycle, set DONE.
      - Else if hold or !EN: stay LOW, timer held at 0.
      - Else: timer=PULSE_W-1, →HIGH.
- Timing:
  - CMD write in cycle t → popped at t+1 → line high in cycle t+2.
  - Rising edges within one command are exactly Peff clocks apart.
  - Between back-to-back commands the spacing is Peff+1 (one IDLE cycle).
- EN=0 and hold never truncate a pulse in progress; they take effect only at the LOW→HIGH boundary.
- PERIOD write mid-command takes effect at the next timer load.
- NET clear coincident with a HIGH entry: clear wins; that spike is not counted.
- DONE set and W1C in the same cycle: set wins.
- user_interrupt = DONE & IRQ_EN, registered.
- Reset asserted mid-pulse forces all outputs to reset values immediately (asynchronous).

Test Plan:
- PERIOD=4, EN=1, push {dir0, count3} at t → uo_out[0] high in cycles t+2, t+6, t+10 only; NET=0x0000_0003; DONE=1; with IRQ_EN, user_interrupt=1 one cycle after DONE sets.
- EN=0, push 5 commands → level=4, full=1, OVF=1; write 0x40 to STATUS → OVF=0; FIFO contents unchanged.
- {dir2, count2} from NET=0 → NET[15:0]=0xFFFE.
- Push {dir1, count0} then {dir1, count1} → zero-count command skipped; one spike on uo_out[1]; net_y=1.
- count 10, hold=1 after the 2nd spike → line stays low while held, CUR=8; release → remaining 8 spikes resume at Peff spacing.
- Mid-command FLUSH → next cycle busy=0, empty=1, uo_out[3:0]=0, DONE stays 0; PERIOD=1 with PULSE_W=1 → Peff=2.
